// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters
// Ports: clk_in/reset_in write-domain clock and sync active-high reset; req_in/data_in per-requester
// word-valid and packed words; fifo_full_in FIFO full flag; grant_out registered one-hot grant;
// ack_out word-accepted strobe; fifo_w_request_out/fifo_w_data_out FIFO write port; busy_out in GRANT.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk_in,
    input  logic                            reset_in,
    input  logic [NUM_REQ-1:0]              req_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in,
    input  logic                            fifo_full_in,
    output logic [NUM_REQ-1:0]              grant_out,
    output logic [NUM_REQ-1:0]              ack_out,
    output logic                            fifo_w_request_out,
    output logic [DATA_WIDTH-1:0]           fifo_w_data_out,
    output logic                            busy_out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            state, state_nx;
    logic [NUM_REQ-1:0] grant_nx;
    logic [IW-1:0]     last, last_nx, sel;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              rel;
    // last doubles as the current grant index: it is updated whenever a grant is issued
    always_comb begin
        sel = last;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_in[IW'((int'(last) + k) % NUM_REQ)]) sel = IW'((int'(last) + k) % NUM_REQ);
    end
    // reset gating keeps the reset cycle from writing a word the arbiter then forgets
    assign ack_out            = grant_out & req_in & {NUM_REQ{~fifo_full_in & ~reset_in}};
    assign fifo_w_request_out = |ack_out;
    assign fifo_w_data_out    = |grant_out ? data_in[int'(last)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign busy_out           = state == GRANT;
    assign rel = state == GRANT && (!req_in[last] || (fifo_w_request_out && cnt == CW'(MAX_BURST - 1)));
    always_comb begin
        state_nx = state;
        grant_nx = grant_out;
        last_nx  = last;
        cnt_nx   = cnt + CW'(fifo_w_request_out);
        if (state == IDLE || rel) begin
            state_nx = |req_in ? GRANT : IDLE;
            grant_nx = '0;
            if (|req_in) grant_nx[sel] = 1'b1;
            last_nx  = |req_in ? sel : last;
            cnt_nx   = '0;
        end
    end
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= IDLE;
            grant_out <= '0;
            cnt       <= '0;
            last      <= IW'(NUM_REQ - 1);
        end else begin
            state     <= state_nx;
            grant_out <= grant_nx;
            cnt       <= cnt_nx;
            last      <= last_nx;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [3:0]  req_in = '0;
    logic [15:0] data_in = '0;
    logic        fifo_full_in = 1'b0;
    logic [3:0]  grant_out, ack_out;
    logic        fifo_w_request_out, busy_out;
    logic [3:0]  fifo_w_data_out;
    logic [13:0] obs, ex;
    int errors = 0;
    int checks = 0;
    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(4)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req_in(req_in), .data_in(data_in),
        .fifo_full_in(fifo_full_in), .grant_out(grant_out), .ack_out(ack_out),
        .fifo_w_request_out(fifo_w_request_out), .fifo_w_data_out(fifo_w_data_out),
        .busy_out(busy_out)
    );
    always #5 clk_in = ~clk_in;
    assign obs = {grant_out, ack_out, fifo_w_request_out, fifo_w_data_out, busy_out};

    task automatic step(input logic [3:0] r, input logic [15:0] d, input logic f, input logic rs);
        @(posedge clk_in);
        #1;
        req_in = r;
        data_in = d;
        fifo_full_in = f;
        reset_in = rs;
        @(negedge clk_in);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 16'hFFFF, 1'b0, 1'b1);
            ex = '0;
            checks++;
            if (obs !== ex) begin errors++; $display("FAIL reset[%0d] got=%h exp=%h", i, obs, ex); end
        end
    endtask

    task automatic test_single;
        step(4'b0001, 16'h0, 1'b0, 1'b0);
        ex = '0;
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL single_latency got=%h exp=%h", obs, ex); end
        for (int w = 0; w < 6; w++) begin
            step(4'b0001, {12'h0, 4'(w)}, 1'b0, 1'b0);
            ex = {4'b0001, 4'b0001, 1'b1, 4'(w), 1'b1};
            checks++;
            if (obs !== ex) begin errors++; $display("FAIL single_word[%0d] got=%h exp=%h", w, obs, ex); end
        end
        step(4'b0000, 16'h0, 1'b0, 1'b0);
        ex = {4'b0001, 4'b0000, 1'b0, 4'h0, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL single_drop got=%h exp=%h", obs, ex); end
        step(4'b0000, 16'h0, 1'b0, 1'b0);
        ex = '0;
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL single_idle got=%h exp=%h", obs, ex); end
    endtask

    task automatic test_rotation;
        logic [3:0] g;
        step(4'b0000, 16'h0, 1'b0, 1'b1);
        step(4'b0111, 16'hBA98, 1'b0, 1'b0);
        ex = '0;
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL rot_latency got=%h exp=%h", obs, ex); end
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++) begin
                step(4'b0111, 16'hBA98, 1'b0, 1'b0);
                g = (b == 3) ? 4'd0 : 4'(b);
                ex = {4'b0001 << g, 4'b0001 << g, 1'b1, 4'd8 + g, 1'b1};
                checks++;
                if (obs !== ex) begin errors++; $display("FAIL rot[%0d.%0d] got=%h exp=%h", b, k, obs, ex); end
            end
        step(4'b0000, 16'hBA98, 1'b0, 1'b0);
        ex = {4'b0010, 4'b0000, 1'b0, 4'h9, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL rot_next got=%h exp=%h", obs, ex); end
    endtask

    task automatic test_full;
        step(4'b0000, 16'h0, 1'b0, 1'b1);
        step(4'b0011, 16'hBA98, 1'b0, 1'b0);
        step(4'b0011, 16'hBA98, 1'b0, 1'b0);
        ex = {4'b0001, 4'b0001, 1'b1, 4'h8, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL full_first got=%h exp=%h", obs, ex); end
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 16'hBA98, 1'b1, 1'b0);
            ex = {4'b0001, 4'b0000, 1'b0, 4'h8, 1'b1};
            checks++;
            if (obs !== ex) begin errors++; $display("FAIL full_stall[%0d] got=%h exp=%h", i, obs, ex); end
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 16'hBA98, 1'b0, 1'b0);
            ex = {4'b0001, 4'b0001, 1'b1, 4'h8, 1'b1};
            checks++;
            if (obs !== ex) begin errors++; $display("FAIL full_resume[%0d] got=%h exp=%h", i, obs, ex); end
        end
        step(4'b0011, 16'hBA98, 1'b0, 1'b0);
        ex = {4'b0010, 4'b0010, 1'b1, 4'h9, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL full_rotate got=%h exp=%h", obs, ex); end
    endtask

    task automatic test_drop_reset;
        step(4'b0000, 16'h0, 1'b0, 1'b1);
        step(4'b0011, 16'hBA98, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(4'b0011, 16'hBA98, 1'b0, 1'b0);
            ex = {4'b0001, 4'b0001, 1'b1, 4'h8, 1'b1};
            checks++;
            if (obs !== ex) begin errors++; $display("FAIL drop_ack[%0d] got=%h exp=%h", i, obs, ex); end
        end
        step(4'b0010, 16'hBA98, 1'b0, 1'b0);
        ex = {4'b0001, 4'b0000, 1'b0, 4'h8, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL drop_release got=%h exp=%h", obs, ex); end
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, 16'hBA98, 1'b0, 1'b0);
            ex = {4'b0010, 4'b0010, 1'b1, 4'h9, 1'b1};
            checks++;
            if (obs !== ex) begin errors++; $display("FAIL drop_new[%0d] got=%h exp=%h", i, obs, ex); end
        end
        step(4'b0011, 16'hBA98, 1'b0, 1'b0);
        ex = {4'b0001, 4'b0001, 1'b1, 4'h8, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL drop_rotate got=%h exp=%h", obs, ex); end
        step(4'b0011, 16'hBA98, 1'b0, 1'b1);
        ex = {4'b0001, 4'b0000, 1'b0, 4'h8, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL midreset_cycle got=%h exp=%h", obs, ex); end
        step(4'b0011, 16'hBA98, 1'b0, 1'b0);
        ex = '0;
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL midreset_drop got=%h exp=%h", obs, ex); end
        step(4'b0011, 16'hBA98, 1'b0, 1'b0);
        ex = {4'b0001, 4'b0001, 1'b1, 4'h8, 1'b1};
        checks++;
        if (obs !== ex) begin errors++; $display("FAIL midreset_winner got=%h exp=%h", obs, ex); end
    endtask

    task automatic test_fifo;
        logic [3:0] q[$];
        logic [3:0] log_q[$];
        logic [3:0] rd, want;
        int seq[2];
        int nread;
        bit seen_full;
        seq = '{0, 0};
        nread = 0;
        seen_full = 0;
        step(4'b0000, 16'h0, 1'b0, 1'b1);
        for (int c = 0; c < 400 && nread < 16; c++) begin
            @(posedge clk_in);
            #1;
            reset_in = 1'b0;
            if (c % 3 == 2 && q.size() > 0) begin
                rd = q.pop_front();
                want = log_q.pop_front();
                nread++;
                checks++;
                if (rd !== want) begin errors++; $display("FAIL fifo_order[%0d] got=%h exp=%h", nread, rd, want); end
            end
            fifo_full_in = q.size() >= 8;
            req_in = {2'b00, seq[1] < 8, seq[0] < 8};
            data_in = {8'h0, 1'b1, 3'(seq[1]), 1'b0, 3'(seq[0])};
            @(negedge clk_in);
            if (fifo_full_in) seen_full = 1;
            for (int i = 0; i < 2; i++)
                if (ack_out[i]) begin
                    log_q.push_back(data_in[i*4 +: 4]);
                    seq[i]++;
                end
            checks++;
            if (fifo_full_in && fifo_w_request_out !== 1'b0) begin
                errors++;
                $display("FAIL fifo_write_while_full got=%b exp=0", fifo_w_request_out);
            end
            if (fifo_w_request_out === 1'b1 && !fifo_full_in) q.push_back(fifo_w_data_out);
        end
        checks++;
        if (nread != 16) begin errors++; $display("FAIL fifo_count got=%0d exp=16", nread); end
        checks++;
        if (!seen_full) begin errors++; $display("FAIL fifo_full_seen got=0 exp=1"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_full();
        test_drop_reset();
        test_fifo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
